// File: rtl/wishbone_1mst_to_nslv.sv
// Wishbone classic interconnect: one master to NB_SLV slaves, registered request/response path.
// Defining WB_ICN_TIMEOUT_EN adds a bus-timeout watchdog (TIMEOUT cycles in ACCESS).

package wishbone_1mst_to_nslv_pkg;
    localparam int unsigned MAX_SLV = 16;

    // Slot i decodes the 64 KiB window at 0x3000_0000 + (i << 16).
    function automatic logic [MAX_SLV*32-1:0] default_addr_base();
        logic [MAX_SLV*32-1:0] v;
        v = '0;
        for (int i = 0; i < int'(MAX_SLV); i++)
            v[32*i +: 32] = 32'h3000_0000 + (32'(i) << 16);
        return v;
    endfunction
endpackage

module wishbone_1mst_to_nslv
    import wishbone_1mst_to_nslv_pkg::*;
#(
    parameter int unsigned          NB_SLV    = 8,
    parameter logic [NB_SLV*32-1:0] ADDR_BASE = (NB_SLV*32)'(default_addr_base()),
    parameter logic [NB_SLV*32-1:0] ADDR_MASK = {NB_SLV{32'hFFFF_0000}},
    parameter logic [31:0]          ERR_DATA  = 32'hDEAD_BEEF
`ifdef WB_ICN_TIMEOUT_EN
    ,
    parameter int unsigned          TIMEOUT   = 1024
`endif
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   wbs_m_cyc_i,
    input  logic                   wbs_m_stb_i,
    input  logic                   wbs_m_we_i,
    input  logic [31:0]            wbs_m_adr_i,
    input  logic [31:0]            wbs_m_dat_i,
    input  logic [3:0]             wbs_m_sel_i,
    output logic [31:0]            wbs_m_dat_o,
    output logic                   wbs_m_ack_o,
    output logic [NB_SLV-1:0]      wbs_s_cyc_o,
    output logic [NB_SLV-1:0]      wbs_s_stb_o,
    output logic [31:0]            wbs_s_adr_o,
    output logic [31:0]            wbs_s_dat_o,
    output logic                   wbs_s_we_o,
    output logic [3:0]             wbs_s_sel_o,
    input  logic [NB_SLV*32-1:0]   wbs_s_dat_i,
    input  logic [NB_SLV-1:0]      wbs_s_ack_i,
    output logic                   err_o,
    output logic [31:0]            err_adr_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]        r_state;
    logic [NB_SLV-1:0] r_s_stb;
    logic [31:0]       r_s_adr;
    logic [31:0]       r_s_dat;
    logic              r_s_we;
    logic [3:0]        r_s_sel;
    logic [31:0]       r_m_dat;
    logic              r_m_ack;
    logic              r_err;
    logic [31:0]       r_err_adr;

    logic [NB_SLV-1:0] w_hit_oh;
    logic              w_sel_ack;
    logic [31:0]       w_sel_dat;
    logic              w_expire;

    // Scan from the top slot down so the lowest matching index is the one left standing.
    // NOTE: w_hit_oh is defaulted before the loop so the decode is purely combinational.
    always_comb begin
        w_hit_oh = '0;
        for (int i = int'(NB_SLV) - 1; i >= 0; i--) begin
            if ((wbs_m_adr_i & ADDR_MASK[32*i +: 32]) == ADDR_BASE[32*i +: 32]) begin
                w_hit_oh    = '0;
                w_hit_oh[i] = 1'b1;
            end
        end
    end

    // The registered one-hot strobe doubles as the response select, so stray acks are masked.
    always_comb begin
        w_sel_dat = '0;
        for (int i = 0; i < int'(NB_SLV); i++)
            if (r_s_stb[i]) w_sel_dat = w_sel_dat | wbs_s_dat_i[32*i +: 32];
    end

    assign w_sel_ack = |(wbs_s_ack_i & r_s_stb);

`ifdef WB_ICN_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] r_tmo_cnt;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            r_tmo_cnt <= '0;
        else if (r_state != S_ACCESS)
            r_tmo_cnt <= '0;
        else
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
    end

    assign w_expire = (r_state == S_ACCESS) && (r_tmo_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign w_expire = 1'b0;
`endif

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state   <= S_IDLE;
            r_s_stb   <= '0;
            r_s_adr   <= '0;
            r_s_dat   <= '0;
            r_s_we    <= 1'b0;
            r_s_sel   <= '0;
            r_m_dat   <= '0;
            r_m_ack   <= 1'b0;
            r_err     <= 1'b0;
            r_err_adr <= '0;
        end else begin
            r_m_ack <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wbs_m_cyc_i && wbs_m_stb_i) begin
                        r_s_adr <= wbs_m_adr_i;
                        r_s_dat <= wbs_m_dat_i;
                        r_s_we  <= wbs_m_we_i;
                        r_s_sel <= wbs_m_sel_i;
                        if (|w_hit_oh) begin
                            r_s_stb <= w_hit_oh;
                            r_state <= S_ACCESS;
                        end else begin
                            r_m_dat   <= ERR_DATA;
                            r_m_ack   <= 1'b1;
                            r_err     <= 1'b1;
                            r_err_adr <= wbs_m_adr_i;
                            r_state   <= S_RESP;
                        end
                    end
                end
                S_ACCESS: begin
                    if (!wbs_m_cyc_i) begin
                        r_s_stb <= '0;
                        r_state <= S_IDLE;
                    end else if (w_sel_ack) begin
                        r_m_dat <= w_sel_dat;
                        r_m_ack <= 1'b1;
                        r_s_stb <= '0;
                        r_state <= S_RESP;
                    end else if (w_expire) begin
                        r_m_dat   <= ERR_DATA;
                        r_m_ack   <= 1'b1;
                        r_err     <= 1'b1;
                        r_err_adr <= r_s_adr;
                        r_s_stb   <= '0;
                        r_state   <= S_RESP;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wbs_m_dat_o = r_m_dat;
    assign wbs_m_ack_o = r_m_ack;
    assign wbs_s_cyc_o = r_s_stb;
    assign wbs_s_stb_o = r_s_stb;
    assign wbs_s_adr_o = r_s_adr;
    assign wbs_s_dat_o = r_s_dat;
    assign wbs_s_we_o  = r_s_we;
    assign wbs_s_sel_o = r_s_sel;
    assign err_o       = r_err;
    assign err_adr_o   = r_err_adr;

endmodule
